mem_stage: RTL and testbench

- Memory-access stage of the 5-stage RV32I pipeline.
- Consumes the EX/MEM pipeline register outputs and runs the data-memory transaction over a req/ready handshake.
- Handles byte/half/word lane steering and load sign/zero extension.
- Drives the registered MEM/WB outputs and raises a pipeline stall while a memory access waits on the bus.

---
 rtl/riscv_pkg.sv | 38 +++
 rtl/lsu_align.sv | 70 +++++++
 rtl/mem_stage.sv | 132 +++++++++++++
 tb/tb_mem_stage.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: load/store funct3 codes, access sizes and mem-stage state encoding.
// Latency: none (package only).
// Backpressure: not applicable.
package riscv_pkg;

    // Load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Memory-stage handshake state
    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_WAIT = 1'b1
    } ms_state_t;

    // Access width derived from funct3
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } acc_size_t;

    // Undefined encodings (011, 110, 111) fall back to a full word
    function automatic acc_size_t f3_size(input logic [2:0] f3);
        acc_size_t sz;
        sz = SZ_W;
        case (f3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables/replicated data, load extraction/extension, misalign detect.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    acc_size_t   size;
    logic        is_unsigned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign size        = f3_size(funct3);
    assign is_unsigned = funct3[2];

    // Store side: lane enables, replicated data and alignment check by access size
    always_comb begin
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = 1'b0;
        case (size)
            SZ_B: begin
                be    = 4'b0001 << addr[1:0];
                wdata = {4{store_data[7:0]}};
            end
            SZ_H: begin
                be         = addr[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                misaligned = addr[0];
            end
            default: begin
                be         = 4'b1111;
                wdata      = store_data;
                misaligned = |addr[1:0];
            end
        endcase
    end

    // Load side: pick the addressed byte/half out of the read word
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr[1:0])
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    // Load side: sign or zero extension; word loads pass straight through
    always_comb begin
        load_data = rdata;
        case (size)
            SZ_B:    load_data = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    load_data = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: runs the data-memory req/ready transaction and registers the MEM/WB outputs.
// Latency: MEM/WB updates 1 cycle after completion (zero-wait access completes in its own cycle).
// Backpressure: stall_o holds upstream while the bus is not ready; accesses abort after MAX_WAIT.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
)
(
    input  logic        clk,
    input  logic        rst_,
    input  logic        mem_valid,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_data,
    input  logic [4:0]  mem_rd_addr,
    input  logic        mem_reg_write,
    input  logic        mem_mem_read,
    input  logic        mem_mem_write,
    input  logic        mem_mem_to_reg,
    input  logic [2:0]  mem_funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall_o,
    output logic        wb_valid,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_rd_addr,
    output logic        wb_reg_write,
    output logic        misaligned_o,
    output logic        bus_err_o
);

    // Counter value on the last WAIT cycle before the access is abandoned
    localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

    ms_state_t   state;
    logic [7:0]  wait_cnt;

    logic        acc;
    logic        misaligned;
    logic        aligned_acc;
    logic        timeout;
    logic        req_int;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    lsu_align u_lsu_align (
        .funct3     (mem_funct3),
        .addr       (mem_alu_result),
        .store_data (mem_data),
        .rdata      (dmem_rdata),
        .be         (st_be),
        .wdata      (st_wdata),
        .load_data  (ld_data),
        .misaligned (misaligned)
    );

    assign acc         = mem_valid & (mem_mem_read | mem_mem_write);
    assign aligned_acc = acc & ~misaligned;
    // Ready wins over timeout when both land on the final WAIT cycle
    assign timeout     = (state == MS_WAIT) & (wait_cnt == LAST_CNT) & ~dmem_ready;

    // rst_ gates the combinational outputs so a reset mid-WAIT drops the request at once
    assign req_int    = rst_ & (((state == MS_IDLE) & aligned_acc) | (state == MS_WAIT));
    assign dmem_req   = req_int;
    assign dmem_we    = req_int & mem_mem_write;
    assign dmem_addr  = req_int ? {mem_alu_result[31:2], 2'b00} : 32'h0;
    assign dmem_be    = req_int ? (mem_mem_write ? st_be : 4'b1111) : 4'b0000;
    assign dmem_wdata = (req_int & mem_mem_write) ? st_wdata : 32'h0;

    // The timeout cycle itself releases the pipeline so the error can retire
    assign stall_o = rst_ & ((((state == MS_IDLE) & aligned_acc) | ((state == MS_WAIT) & ~timeout))
                             & ~dmem_ready);

    // Handshake FSM: park in WAIT until ready arrives or the wait budget runs out
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= MS_IDLE;
            wait_cnt <= 8'd0;
        end else begin
            case (state)
                MS_IDLE: begin
                    if (aligned_acc && !dmem_ready) begin
                        state    <= MS_WAIT;
                        wait_cnt <= 8'd0;
                    end
                end
                MS_WAIT: begin
                    if (dmem_ready || timeout) begin
                        state <= MS_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= MS_IDLE;
                    wait_cnt <= 8'd0;
                end
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, otherwise capture the retiring instruction
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wb_valid     <= 1'b0;
            wb_result    <= 32'h0;
            wb_rd_addr   <= 5'd0;
            wb_reg_write <= 1'b0;
            misaligned_o <= 1'b0;
            bus_err_o    <= 1'b0;
        end else if (stall_o) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            misaligned_o <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            wb_valid     <= mem_valid;
            wb_result    <= mem_mem_to_reg ? ld_data : mem_alu_result;
            wb_rd_addr   <= mem_rd_addr;
            wb_reg_write <= mem_valid & mem_reg_write & ~(acc & misaligned) & ~timeout;
            misaligned_o <= acc & misaligned;
            bus_err_o    <= timeout;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, reset sequences and random accesses.
// Latency: checks MEM/WB one cycle after each access completes.
// Backpressure: bench holds EX/MEM inputs steady while stall_o is expected high.
module tb_mem_stage;

    localparam int MW = 4;

    logic        clk;
    logic        rst_;
    logic        mem_valid;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_data;
    logic [4:0]  mem_rd_addr;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic        mem_mem_to_reg;
    logic [2:0]  mem_funct3;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall_o;
    logic        wb_valid;
    logic [31:0] wb_result;
    logic [4:0]  wb_rd_addr;
    logic        wb_reg_write;
    logic        misaligned_o;
    logic        bus_err_o;

    mem_stage #(.MAX_WAIT(MW)) dut (
        .clk            (clk),
        .rst_           (rst_),
        .mem_valid      (mem_valid),
        .mem_alu_result (mem_alu_result),
        .mem_data       (mem_data),
        .mem_rd_addr    (mem_rd_addr),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .mem_mem_to_reg (mem_mem_to_reg),
        .mem_funct3     (mem_funct3),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_be        (dmem_be),
        .dmem_ready     (dmem_ready),
        .dmem_rdata     (dmem_rdata),
        .stall_o        (stall_o),
        .wb_valid       (wb_valid),
        .wb_result      (wb_result),
        .wb_rd_addr     (wb_rd_addr),
        .wb_reg_write   (wb_reg_write),
        .misaligned_o   (misaligned_o),
        .bus_err_o      (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access: EX/MEM inputs, cycle on which ready rises, read data, then expectations
    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        rd_en;
        logic        wr_en;
        logic        m2r;
        logic [2:0]  f3;
        int          dly;
        logic [31:0] rdata;
        logic        e_req;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        int          e_stall;
        logic [31:0] e_result;
        logic        e_rw;
        logic        e_mis;
        logic        e_err;
        logic        e_chk;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [4:0]  prev_rd;
    logic [31:0] prev_res;
    logic        prev_known;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: derives the outcome from access size, byte offset and ready delay
    function automatic vec_t model(input vec_t vi);
        vec_t        v;
        int          size;
        int          off;
        logic [31:0] mask;
        logic [31:0] raw;
        logic        acc;
        logic        mis;
        logic        tmo;
        v = vi;
        case (v.f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            default:        size = 4;
        endcase
        off  = int'(v.addr % 4);
        acc  = v.valid & (v.rd_en | v.wr_en);
        mis  = acc && ((v.addr % size) != 0);
        tmo  = acc && !mis && (v.dly > MW);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        v.e_req   = acc & !mis;
        v.e_be    = 4'(((1 << size) - 1) << off);
        v.e_wdata = (size == 1) ? (v.data & 32'hFF) * 32'h0101_0101 :
                    (size == 2) ? (v.data & 32'hFFFF) * 32'h0001_0001 : v.data;
        raw = (v.rdata >> (8 * off)) & mask;
        if (size < 4 && !v.f3[2] && raw[8 * size - 1]) raw = raw | ~mask;
        v.e_result = v.m2r ? raw : v.addr;
        v.e_stall  = !v.e_req ? 0 : (tmo ? MW : v.dly);
        v.e_rw     = v.valid & v.rw & !mis & !tmo;
        v.e_mis    = mis;
        v.e_err    = tmo;
        v.e_chk    = !(v.m2r & (mis | tmo));
        return v;
    endfunction

    // Drive one access (called just after a rising edge), hold it through the stall, check MEM/WB
    task automatic run_access(input vec_t v);
        mem_valid      = v.valid;
        mem_alu_result = v.addr;
        mem_data       = v.data;
        mem_rd_addr    = v.rd;
        mem_reg_write  = v.rw;
        mem_mem_read   = v.rd_en;
        mem_mem_write  = v.wr_en;
        mem_mem_to_reg = v.m2r;
        mem_funct3     = v.f3;
        for (int k = 0; k <= v.e_stall; k++) begin
            dmem_ready = (k == v.dly);
            dmem_rdata = (k == v.dly) ? v.rdata : $urandom;
            @(negedge clk);
            check("dmem_req", {31'b0, dmem_req}, {31'b0, v.e_req});
            check("stall_o", {31'b0, stall_o}, (k < v.e_stall) ? 32'd1 : 32'd0);
            if (v.e_req) begin
                check("dmem_addr", dmem_addr, {v.addr[31:2], 2'b00});
                check("dmem_we", {31'b0, dmem_we}, {31'b0, v.wr_en});
                if (v.wr_en) begin
                    check("dmem_be", {28'b0, dmem_be}, {28'b0, v.e_be});
                    check("dmem_wdata", dmem_wdata, v.e_wdata);
                end
            end
            if (k > 0) begin
                check("bubble_valid", {31'b0, wb_valid}, 32'd0);
                check("bubble_rw", {31'b0, wb_reg_write}, 32'd0);
                check("hold_rd", {27'b0, wb_rd_addr}, {27'b0, prev_rd});
                if (prev_known) check("hold_result", wb_result, prev_res);
            end
            @(posedge clk);
            #1;
        end
        check("wb_valid", {31'b0, wb_valid}, {31'b0, v.valid});
        check("wb_reg_write", {31'b0, wb_reg_write}, {31'b0, v.e_rw});
        check("wb_rd_addr", {27'b0, wb_rd_addr}, {27'b0, v.rd});
        if (v.e_chk) check("wb_result", wb_result, v.e_result);
        check("misaligned_o", {31'b0, misaligned_o}, {31'b0, v.e_mis});
        check("bus_err_o", {31'b0, bus_err_o}, {31'b0, v.e_err});
        prev_rd    = v.rd;
        prev_res   = v.e_result;
        prev_known = v.e_chk;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, {31'b0, dmem_req}, 32'd0);
        check({tag, "_stall"}, {31'b0, stall_o}, 32'd0);
        check({tag, "_addr"}, dmem_addr, 32'd0);
        check({tag, "_wb_valid"}, {31'b0, wb_valid}, 32'd0);
        check({tag, "_wb_result"}, wb_result, 32'd0);
        check({tag, "_wb_rd"}, {27'b0, wb_rd_addr}, 32'd0);
        check({tag, "_wb_rw"}, {31'b0, wb_reg_write}, 32'd0);
        check({tag, "_mis"}, {31'b0, misaligned_o}, 32'd0);
        check({tag, "_err"}, {31'b0, bus_err_o}, 32'd0);
    endtask

    vec_t tbl[16];
    vec_t rv;

    initial begin
        // Directed vectors with hand-derived expectations (MAX_WAIT = 4)
        //          valid addr          data           rd    rw    rd_en wr_en m2r   f3      dly rdata
        //          req   be      wdata          stall result        rw    mis   err   chk
        tbl[0]  = '{1'b1, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 0, 32'h0,
                    1'b1, 4'hF, 32'hDEADBEEF, 0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 32'h103, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 0, 32'h80FF0000,
                    1'b1, 4'h0, 32'h0, 0, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 32'h103, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 0, 32'h80FF0000,
                    1'b1, 4'h0, 32'h0, 0, 32'h00000080, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 32'h202, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 3'b101, 2, 32'hABCD1234,
                    1'b1, 4'h0, 32'h0, 2, 32'h0000ABCD, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 32'h101, 32'h5678, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 0, 32'h0,
                    1'b0, 4'h0, 32'h0, 0, 32'h101, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 32'h102, 32'hAA, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 0, 32'h0,
                    1'b1, 4'b0100, 32'hAAAAAAAA, 0, 32'h102, 1'b0, 1'b0, 1'b0, 1'b1};
        // Ready never arrives: request cycle plus MAX_WAIT-1 WAIT cycles stall, then the abort cycle
        tbl[6]  = '{1'b1, 32'h300, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 99, 32'h0,
                    1'b1, 4'h0, 32'h0, 4, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        // Ready on the last WAIT cycle still completes normally
        tbl[7]  = '{1'b1, 32'h304, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 4, 32'hCAFEF00D,
                    1'b1, 4'h0, 32'h0, 4, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 32'h106, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 0, 32'h0,
                    1'b0, 4'h0, 32'h0, 0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 32'h12345678, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 0, 32'h0,
                    1'b0, 4'h0, 32'h0, 0, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 32'h55, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 0, 32'h1111,
                    1'b0, 4'h0, 32'h0, 0, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 32'h200, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 0, 32'h00008001,
                    1'b1, 4'h0, 32'h0, 0, 32'hFFFF8001, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 32'h10, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 1, 32'h87654321,
                    1'b1, 4'h0, 32'h0, 1, 32'h87654321, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 32'h14, 32'h0, 5'd14, 1'b1, 1'b1, 1'b0, 1'b1, 3'b110, 0, 32'h80000001,
                    1'b1, 4'h0, 32'h0, 0, 32'h80000001, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 32'h102, 32'h12345678, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 0, 32'h0,
                    1'b1, 4'b1100, 32'h56785678, 0, 32'h102, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 32'h101, 32'h0, 5'd15, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 0, 32'h00007F00,
                    1'b1, 4'h0, 32'h0, 0, 32'h0000007F, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset with a pending aligned load on the inputs: everything must read 0
        rst_           = 1'b0;
        mem_valid      = 1'b1;
        mem_alu_result = 32'h40;
        mem_data       = 32'h0;
        mem_rd_addr    = 5'd9;
        mem_reg_write  = 1'b1;
        mem_mem_read   = 1'b1;
        mem_mem_write  = 1'b0;
        mem_mem_to_reg = 1'b1;
        mem_funct3     = 3'b010;
        dmem_ready     = 1'b0;
        dmem_rdata     = 32'h0;
        #3;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_       = 1'b1;
        prev_rd    = 5'd0;
        prev_res   = 32'h0;
        prev_known = 1'b1;

        for (int i = 0; i < 16; i++) run_access(tbl[i]);

        // Reset asserted mid-WAIT drops the request and clears MEM/WB without a clock edge
        mem_valid      = 1'b1;
        mem_alu_result = 32'h40;
        mem_rd_addr    = 5'd9;
        mem_reg_write  = 1'b1;
        mem_mem_read   = 1'b1;
        mem_mem_write  = 1'b0;
        mem_mem_to_reg = 1'b1;
        mem_funct3     = 3'b010;
        dmem_ready     = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midwait_req", {31'b0, dmem_req}, 32'd1);
        check("midwait_stall", {31'b0, stall_o}, 32'd1);
        rst_ = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        check_all_zero("reset_held");
        rst_       = 1'b1;
        prev_rd    = 5'd0;
        prev_res   = 32'h0;
        prev_known = 1'b1;
        rv = '{1'b1, 32'h44, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 1, 32'h0BADF00D,
               1'b1, 4'h0, 32'h0, 1, 32'h0BADF00D, 1'b1, 1'b0, 1'b0, 1'b1};
        run_access(rv);

        // Random accesses against the reference model
        for (int n = 0; n < 300; n++) begin
            int kind;
            kind     = $urandom_range(0, 3);
            rv       = tbl[0];
            rv.addr  = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 1) rv.addr[1:0] = 2'b00;
            rv.data  = $urandom;
            rv.rd    = 5'($urandom);
            rv.f3    = 3'($urandom);
            rv.dly   = $urandom_range(0, 6);
            rv.rdata = $urandom;
            rv.valid = 1'b1;
            rv.rd_en = 1'b0;
            rv.wr_en = 1'b0;
            rv.m2r   = 1'b0;
            rv.rw    = 1'b0;
            case (kind)
                0: begin rv.rd_en = 1'b1; rv.m2r = 1'b1; rv.rw = 1'b1; end
                1: begin rv.wr_en = 1'b1; end
                2: begin rv.rw = 1'($urandom); end
                default: begin
                    rv.valid = 1'b0;
                    rv.rd_en = 1'($urandom);
                    rv.wr_en = 1'($urandom);
                    rv.rw    = 1'($urandom);
                end
            endcase
            run_access(model(rv));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
